// File: rtl/write_register_bank_pkg.sv
// Shared defaults for the write register bank slice.
// Imported by the bank top, its read ports and the bench.
package write_register_bank_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 15;
  localparam int ADDR_W_DEF   = 4;

  localparam logic [3:0] ADDR_ILLEGAL = 4'hF;

endpackage

// File: rtl/write_register_bank_reg_read_port.sv
// Registered read port with write-through bypass.
// Out-of-range addresses read back as invalid zero.
module reg_read_port
  import write_register_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   entries [NUM_REGS],
  input  logic [NUM_REGS-1:0] valid_map,
  input  logic                wr_legal,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

  logic in_range;
  logic hit;

  assign in_range = rd_addr < LIMIT;
  assign hit      = wr_legal && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        !in_range: begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end
        // a same-cycle clear still lands the data but not its valid bit
        hit: begin
          rd_data  <= wr_data;
          rd_valid <= ~clr;
        end
        default: begin
          rd_data  <= entries[rd_addr];
          rd_valid <= valid_map[rd_addr];
        end
      endcase
    end
  end

endmodule

// File: rtl/write_register_bank.sv
// Register bank fed by the write address counter.
// Holds data, a valid map, fill count and two read ports.
module write_register_bank
  import write_register_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid_a,
  output logic                rd_valid_b,
  output logic [NUM_REGS-1:0] valid_map,
  output logic [ADDR_W-1:0]   fill_count,
  output logic                full,
  output logic                wr_err
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] entries [NUM_REGS];
  logic              legal;
  logic              fresh;
  logic [ADDR_W-1:0] count_nxt;

  assign legal = wr_en && (wr_addr < LIMIT);
  assign fresh = legal && !valid_map[wr_addr];

  always_comb begin
    count_nxt = fill_count;
    if (fresh && (fill_count < LIMIT))
      count_nxt = fill_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        entries[i] <= '0;
      valid_map  <= '0;
      fill_count <= '0;
      full       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      if (legal)
        entries[wr_addr] <= wr_data;
      wr_err <= wr_en && !legal;
      if (clr) begin
        valid_map  <= '0;
        fill_count <= '0;
        full       <= 1'b0;
      end else begin
        if (legal)
          valid_map[wr_addr] <= 1'b1;
        fill_count <= count_nxt;
        full       <= (count_nxt == LIMIT);
      end
    end
  end

  reg_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
  ) u_port_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_a),
    .entries(entries), .valid_map(valid_map),
    .wr_legal(legal), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr(clr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  reg_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
  ) u_port_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_b),
    .entries(entries), .valid_map(valid_map),
    .wr_legal(legal), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr(clr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

endmodule

// File: tb/tb_write_register_bank.sv
// Bench for write_register_bank: directed table,
// corner sequences and random traffic against a model.
module tb_write_register_bank;
  import write_register_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        clr;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_a;
  logic        rd_valid_b;
  logic [14:0] valid_map;
  logic [3:0]  fill_count;
  logic        full;
  logic        wr_err;

  always #5 clk = ~clk;

  write_register_bank dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .valid_map(valid_map), .fill_count(fill_count),
    .full(full), .wr_err(wr_err)
  );

  logic [7:0]  m_mem [15];
  logic [14:0] m_valid;
  int          n_chk  = 0;
  int          n_fail = 0;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       c;
    logic [3:0] ra;
    logic [7:0] xd;
    logic       xv;
    logic [3:0] xfill;
    logic       xfull;
    logic       xerr;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic predict(input logic [3:0] ra, input logic leg,
                         input logic [3:0] wa, input logic [7:0] wd,
                         input logic c,
                         output logic [7:0] d, output logic v);
    if (ra >= 4'd15) begin
      d = 8'h00;
      v = 1'b0;
    end else if (leg && wa == ra) begin
      d = wd;
      v = ~c;
    end else begin
      d = m_mem[ra];
      v = m_valid[ra];
    end
  endtask

  task automatic cycle(input logic r, input logic we,
                       input logic [3:0] wa, input logic [7:0] wd,
                       input logic c, input logic [3:0] ra,
                       input logic [3:0] rb);
    logic       leg;
    logic [7:0] eda, edb;
    logic       eva, evb, eerr;
    int         cnt;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    clr = c; rd_addr_a = ra; rd_addr_b = rb;
    leg = we && (wa < 4'd15);
    predict(ra, leg, wa, wd, c, eda, eva);
    predict(rb, leg, wa, wd, c, edb, evb);
    eerr = we && !leg;
    if (r) begin
      eda = '0; eva = 1'b0; edb = '0; evb = 1'b0; eerr = 1'b0;
      m_valid = '0;
      for (int i = 0; i < 15; i++) m_mem[i] = '0;
    end else begin
      if (leg) m_mem[wa] = wd;
      if (c) m_valid = '0;
      else if (leg) m_valid[wa] = 1'b1;
    end
    cnt = $countones(m_valid);
    @(posedge clk);
    #1;
    chk("rd_data_a", 32'(rd_data_a), 32'(eda));
    chk("rd_valid_a", 32'(rd_valid_a), 32'(eva));
    chk("rd_data_b", 32'(rd_data_b), 32'(edb));
    chk("rd_valid_b", 32'(rd_valid_b), 32'(evb));
    chk("valid_map", 32'(valid_map), 32'(m_valid));
    chk("fill_count", 32'(fill_count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == 15));
    chk("wr_err", 32'(wr_err), 32'(eerr));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    m_valid = '0;
    for (int i = 0; i < 15; i++) m_mem[i] = '0;

    // reset with a write pending: the write must be dropped
    cycle(1'b1, 1'b1, 4'd3, 8'hAA, 1'b0, 4'd3, 4'd3);
    for (int a = 0; a < 16; a++)
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(a), 4'(15 - a));

    for (int i = 0; i < 15; i++)
      tbl.push_back('{1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'(i),
                      8'(8'h10 + i), 1'b1, 4'(i + 1),
                      (i == 14), 1'b0});
    tbl.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 4'd7,
                    8'h17, 1'b1, 4'd15, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'd2, 8'h99, 1'b1, 4'd2,
                    8'h99, 1'b0, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 4'd2,
                    8'h99, 1'b0, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd3, 8'hAA, 1'b0, 4'd0,
                    8'h10, 1'b0, 4'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd3, 8'h55, 1'b0, 4'd3,
                    8'h55, 1'b1, 4'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 4'd3,
                    8'h55, 1'b1, 4'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd5, 8'h3C, 1'b0, 4'd5,
                    8'h3C, 1'b1, 4'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b1, ADDR_ILLEGAL, 8'h77, 1'b0, 4'hF,
                    8'h00, 1'b0, 4'd2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 4'd5,
                    8'h3C, 1'b1, 4'd2, 1'b0, 1'b0});

    foreach (tbl[k]) begin
      cycle(1'b0, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].c,
            tbl[k].ra, tbl[k].ra ^ 4'd1);
      chk($sformatf("tbl%0d_rd_data", k), 32'(rd_data_a), 32'(tbl[k].xd));
      chk($sformatf("tbl%0d_rd_valid", k), 32'(rd_valid_a), 32'(tbl[k].xv));
      chk($sformatf("tbl%0d_fill", k), 32'(fill_count), 32'(tbl[k].xfill));
      chk($sformatf("tbl%0d_full", k), 32'(full), 32'(tbl[k].xfull));
      chk($sformatf("tbl%0d_wr_err", k), 32'(wr_err), 32'(tbl[k].xerr));
    end

    // reset mid-fill at count 6
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 4'(i), 8'(8'hC0 + i), 1'b0, 4'd0, 4'd1);
    chk("midfill_count", 32'(fill_count), 32'd6);
    cycle(1'b1, 1'b1, 4'd7, 8'hEE, 1'b0, 4'd0, 4'd1);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_map", 32'(valid_map), 32'd0);
    chk("rst_rd_a", 32'(rd_data_a), 32'd0);
    chk("rst_rd_b", 32'(rd_data_b), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd7, 4'd0);
    chk("rst_drop_write", 32'(rd_valid_a), 32'd0);

    // random traffic
    for (int n = 0; n < 500; n++)
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) < 7),
            4'($urandom_range(0, 15)),
            8'($urandom),
            ($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
